// File: rtl/data_ram_pkg.sv
// Shared definitions for the data_ram block-copy engine: FSM encoding,
// command modes and default bus geometry.
package data_ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous RAM; q shows the word addressed in the previous
// cycle (read-before-write on a simultaneous access).
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[address] <= data;
    q <= mem[address];
  end

endmodule

// File: rtl/ram_copy_engine.sv
// Block COPY/FILL initiator for data_ram. COPY alternates RD/WR per word,
// FILL writes one word per cycle; overlapping forward copies run descending.
module ram_copy_engine
  import data_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q;
  logic                  mode_q;
  logic                  desc_q;
  logic                  aborted_q;
  logic [ADDR_WIDTH-1:0] srcPtr_q;
  logic [ADDR_WIDTH-1:0] dstPtr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] fill_q;

  logic [ADDR_WIDTH:0]   startCount_d;
  logic [ADDR_WIDTH-1:0] startDelta_d;
  logic [ADDR_WIDTH-1:0] startSpan_d;
  logic                  startDesc_d;
  logic [ADDR_WIDTH-1:0] srcStart_d;
  logic [ADDR_WIDTH-1:0] dstStart_d;
  logic [ADDR_WIDTH-1:0] srcPtr_d;
  logic [ADDR_WIDTH-1:0] dstPtr_d;

  // Descending order only when the destination lies inside the source window ahead of it.
  always_comb begin
    startCount_d = len[ADDR_WIDTH] ? MAX_COUNT : len;
    startDelta_d = dst_addr - src_addr;
    startSpan_d  = startCount_d[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    startDesc_d  = (mode == MODE_COPY) && (startDelta_d != '0) &&
                   ({1'b0, startDelta_d} < startCount_d);
    srcStart_d   = startDesc_d ? src_addr + startSpan_d : src_addr;
    dstStart_d   = startDesc_d ? dst_addr + startSpan_d : dst_addr;
    srcPtr_d     = desc_q ? srcPtr_q - ADDR_WIDTH'(1) : srcPtr_q + ADDR_WIDTH'(1);
    dstPtr_d     = desc_q ? dstPtr_q - ADDR_WIDTH'(1) : dstPtr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_COPY;
      desc_q    <= 1'b0;
      aborted_q <= 1'b0;
      srcPtr_q  <= '0;
      dstPtr_q  <= '0;
      count_q   <= '0;
      fill_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            desc_q    <= startDesc_d;
            aborted_q <= 1'b0;
            srcPtr_q  <= srcStart_d;
            dstPtr_q  <= dstStart_d;
            count_q   <= startCount_d;
            fill_q    <= fill_data;
            if (startCount_d == '0)      state_q <= ST_FIN;
            else if (mode == MODE_FILL)  state_q <= ST_WR;
            else                         state_q <= ST_RD;
          end
        end
        ST_RD: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= ST_FIN;
          end else begin
            state_q <= ST_WR;
          end
        end
        ST_WR: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= ST_FIN;
          end else begin
            srcPtr_q <= srcPtr_d;
            dstPtr_q <= dstPtr_d;
            count_q  <= count_q - (ADDR_WIDTH+1)'(1);
            if (count_q == (ADDR_WIDTH+1)'(1)) state_q <= ST_FIN;
            else if (mode_q == MODE_FILL)       state_q <= ST_WR;
            else                                state_q <= ST_RD;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM bus is decoded from state so start never reaches it in the same cycle.
  always_comb begin
    busy        = (state_q == ST_RD) || (state_q == ST_WR);
    done        = (state_q == ST_FIN);
    aborted     = (state_q == ST_FIN) && aborted_q;
    ram_we      = (state_q == ST_WR) && !abort;
    ram_address = '0;
    ram_data    = '0;
    if (state_q == ST_RD) begin
      ram_address = srcPtr_q;
    end else if (state_q == ST_WR) begin
      ram_address = dstPtr_q;
      ram_data    = (mode_q == MODE_FILL) ? fill_q : ram_q;
    end
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Self-checking bench: ram_copy_engine driving a data_ram, with a queue of
// expected writes and a shadow memory for read-back of final contents.
module tb_ram_copy_engine;
  import data_ram_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, start, mode, abort;
  logic [7:0] src_addr, dst_addr, fill_data;
  logic [8:0] len;
  logic       busy, done, aborted, ram_we;
  logic [7:0] ram_data, ram_address, ram_q;

  logic       tbOwn, tbWe;
  logic [7:0] tbData, tbAddr;
  logic       memWe;
  logic [7:0] memData, memAddr;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        expQ[$];
  logic [7:0] shadow [256];
  int         checkCount = 0;
  int         passCount  = 0;

  always #5 clk = ~clk;

  assign memWe   = tbOwn ? tbWe   : ram_we;
  assign memData = tbOwn ? tbData : ram_data;
  assign memAddr = tbOwn ? tbAddr : ram_address;

  ram_copy_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .ram_we(ram_we), .ram_data(ram_data), .ram_address(ram_address), .ram_q(ram_q)
  );

  data_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_ram (
    .clk(clk), .we(memWe), .data(memData), .address(memAddr), .q(ram_q)
  );

  // Every engine write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (ram_we === 1'b1 && !tbOwn) begin
      checkCount++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpected_write got addr=%02h data=%02h expected no write", ram_address, ram_data);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        if (ram_address !== e.addr || ram_data !== e.data)
          $display("[TB] FAIL write_seq got addr=%02h data=%02h expected addr=%02h data=%02h",
                   ram_address, ram_data, e.addr, e.data);
        else passCount++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ramWrite(input logic [7:0] a, input logic [7:0] d);
    tbOwn = 1'b1; tbWe = 1'b1; tbAddr = a; tbData = d;
    tick();
    tbWe = 1'b0; tbOwn = 1'b0;
    shadow[a] = d;
  endtask

  task automatic ramRead(input logic [7:0] a, output logic [7:0] d);
    tbOwn = 1'b1; tbWe = 1'b0; tbAddr = a;
    tick();
    d = ram_q;
    tbOwn = 1'b0;
  endtask

  // Reference behaviour: effective count, overlap ordering, wrap-around addresses.
  task automatic modelOp(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] l, input logic [7:0] f, input int maxWrites);
    int         n, idx;
    logic [7:0] delta, a, v;
    bit         desc;
    n     = (int'(l) > 256) ? 256 : int'(l);
    delta = d - s;
    desc  = (m == MODE_COPY) && (delta != 8'd0) && (int'(delta) < n);
    for (int k = 0; k < n && k < maxWrites; k++) begin
      idx = desc ? (n - 1 - k) : k;
      a   = d + 8'(idx);
      v   = (m == MODE_FILL) ? f : shadow[8'(s + 8'(idx))];
      shadow[a] = v;
      expQ.push_back(wr_t'({a, v}));
    end
  endtask

  task automatic issue(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [8:0] l, input logic [7:0] f, input int maxWrites);
    modelOp(m, s, d, l, f, maxWrites);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int busyCycles, output int doneCycle,
                          output bit gotDone, output bit abortSeen);
    busyCycles = 0; doneCycle = -1; gotDone = 1'b0; abortSeen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (done) begin
        gotDone = 1'b1; abortSeen = aborted; doneCycle = i;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; mode = MODE_COPY;
    src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
    tbOwn = 1'b0; tbWe = 1'b0; tbAddr = '0; tbData = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkCount++;
    if ({busy, done, aborted, ram_we, ram_address, ram_data} !== 20'd0)
      $display("[TB] FAIL reset_outputs got busy=%b done=%b aborted=%b we=%b addr=%02h data=%02h expected all 0",
               busy, done, aborted, ram_we, ram_address, ram_data);
    else passCount++;
    tick();
    reset_n = 1'b1;
    tick();
    checkCount++;
    if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL idle_after_reset got busy=%b done=%b expected 0 0", busy, done);
    else passCount++;
  endtask

  task automatic test_fill();
    int bc, dc; bit gd, ab; logic [7:0] got;
    for (int i = 0; i < 5; i++) ramWrite(8'h10 + 8'(i), 8'h70 + 8'(i));
    issue(MODE_FILL, 8'h99, 8'h10, 9'd4, 8'hA5, 999);
    waitDone(20, bc, dc, gd, ab);
    checkCount++;
    if (!gd || ab || bc != 4 || dc != 4)
      $display("[TB] FAIL fill_timing got done=%b aborted=%b busy=%0d doneAt=%0d expected 1 0 4 4", gd, ab, bc, dc);
    else passCount++;
    checkCount++;
    if (expQ.size() != 0) $display("[TB] FAIL fill_writes got %0d outstanding expected 0", expQ.size());
    else passCount++;
    for (int i = 0; i < 5; i++) begin
      ramRead(8'h10 + 8'(i), got);
      checkCount++;
      if (got !== shadow[8'h10 + 8'(i)])
        $display("[TB] FAIL fill_mem[%02h] got=%02h expected=%02h", 8'h10 + 8'(i), got, shadow[8'h10 + 8'(i)]);
      else passCount++;
    end
  endtask

  task automatic test_copy();
    int bc, dc; bit gd, ab; logic [7:0] got;
    ramWrite(8'h20, 8'd11); ramWrite(8'h21, 8'd22); ramWrite(8'h22, 8'd33);
    for (int i = 0; i < 3; i++) ramWrite(8'h40 + 8'(i), 8'h00);
    issue(MODE_COPY, 8'h20, 8'h40, 9'd3, 8'h00, 999);
    waitDone(30, bc, dc, gd, ab);
    checkCount++;
    if (!gd || ab || bc != 6 || dc != 6)
      $display("[TB] FAIL copy_timing got done=%b aborted=%b busy=%0d doneAt=%0d expected 1 0 6 6", gd, ab, bc, dc);
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      ramRead(8'h40 + 8'(i), got);
      checkCount++;
      if (got !== shadow[8'h40 + 8'(i)])
        $display("[TB] FAIL copy_mem[%02h] got=%02h expected=%02h", 8'h40 + 8'(i), got, shadow[8'h40 + 8'(i)]);
      else passCount++;
    end
  endtask

  task automatic test_overlap();
    int bc, dc; bit gd, ab; logic [7:0] got;
    for (int i = 0; i < 4; i++) ramWrite(8'(i), 8'(i + 1));
    ramWrite(8'h04, 8'hEE); ramWrite(8'h05, 8'hEE);
    issue(MODE_COPY, 8'h00, 8'h02, 9'd4, 8'h00, 999);
    waitDone(30, bc, dc, gd, ab);
    checkCount++;
    if (!gd || bc != 8 || expQ.size() != 0)
      $display("[TB] FAIL overlap_run got done=%b busy=%0d outstanding=%0d expected 1 8 0", gd, bc, expQ.size());
    else passCount++;
    for (int i = 0; i < 6; i++) begin
      ramRead(8'(i), got);
      checkCount++;
      if (got !== shadow[8'(i)]) $display("[TB] FAIL overlap_mem[%02h] got=%02h expected=%02h", 8'(i), got, shadow[8'(i)]);
      else passCount++;
    end
  endtask

  task automatic test_wrap_and_zero();
    int bc, dc; bit gd, ab; logic [7:0] got; logic [7:0] addrs [5];
    addrs = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    ramWrite(8'hFE, 8'h00); ramWrite(8'hFF, 8'h00);
    issue(MODE_FILL, 8'h00, 8'hFE, 9'd4, 8'h5A, 999);
    waitDone(20, bc, dc, gd, ab);
    checkCount++;
    if (!gd || bc != 4 || expQ.size() != 0)
      $display("[TB] FAIL wrap_run got done=%b busy=%0d outstanding=%0d expected 1 4 0", gd, bc, expQ.size());
    else passCount++;
    for (int i = 0; i < 5; i++) begin
      ramRead(addrs[i], got);
      checkCount++;
      if (got !== shadow[addrs[i]]) $display("[TB] FAIL wrap_mem[%02h] got=%02h expected=%02h", addrs[i], got, shadow[addrs[i]]);
      else passCount++;
    end
    issue(MODE_COPY, 8'h00, 8'h01, 9'd0, 8'h00, 999);
    waitDone(10, bc, dc, gd, ab);
    checkCount++;
    if (!gd || ab || bc != 0 || dc != 0)
      $display("[TB] FAIL zero_len got done=%b aborted=%b busy=%0d doneAt=%0d expected 1 0 0 0", gd, ab, bc, dc);
    else passCount++;
  endtask

  task automatic test_abort();
    logic [7:0] got;
    for (int i = 0; i < 8; i++) ramWrite(8'h60 + 8'(i), 8'hC0 + 8'(i));
    for (int i = 0; i < 8; i++) ramWrite(8'h80 + 8'(i), 8'h00);
    issue(MODE_COPY, 8'h60, 8'h80, 9'd8, 8'h00, 2);
    repeat (5) tick();
    abort = 1'b1;
    @(negedge clk);
    checkCount++;
    if (ram_we !== 1'b0 || busy !== 1'b1 || ram_address !== 8'h82)
      $display("[TB] FAIL abort_suppress got we=%b busy=%b addr=%02h expected 0 1 82", ram_we, busy, ram_address);
    else passCount++;
    tick();
    abort = 1'b0;
    @(negedge clk);
    checkCount++;
    if (done !== 1'b1 || aborted !== 1'b1) $display("[TB] FAIL abort_done got done=%b aborted=%b expected 1 1", done, aborted);
    else passCount++;
    tick();
    checkCount++;
    if (expQ.size() != 0) $display("[TB] FAIL abort_writes got %0d outstanding expected 0", expQ.size());
    else passCount++;
    for (int i = 0; i < 8; i++) begin
      ramRead(8'h80 + 8'(i), got);
      checkCount++;
      if (got !== shadow[8'h80 + 8'(i)])
        $display("[TB] FAIL abort_mem[%02h] got=%02h expected=%02h", 8'h80 + 8'(i), got, shadow[8'h80 + 8'(i)]);
      else passCount++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got; bit stray;
    for (int i = 0; i < 4; i++) ramWrite(8'hA0 + 8'(i), 8'h00);
    issue(MODE_COPY, 8'h60, 8'hA0, 9'd4, 8'h00, 1);
    tick();
    reset_n = 1'b0; start = 1'b1; mode = MODE_FILL; len = 9'd4;
    tick();
    @(negedge clk);
    checkCount++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL reset_mid got busy=%b we=%b done=%b expected 0 0 0", busy, ram_we, done);
    else passCount++;
    tick();
    reset_n = 1'b1; start = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) stray = 1'b1;
    end
    tick();
    checkCount++;
    if (stray || expQ.size() != 0)
      $display("[TB] FAIL reset_quiet got activity=%b outstanding=%0d expected 0 0", stray, expQ.size());
    else passCount++;
    for (int i = 0; i < 4; i++) begin
      ramRead(8'hA0 + 8'(i), got);
      checkCount++;
      if (got !== shadow[8'hA0 + 8'(i)])
        $display("[TB] FAIL reset_mem[%02h] got=%02h expected=%02h", 8'hA0 + 8'(i), got, shadow[8'hA0 + 8'(i)]);
      else passCount++;
    end
  endtask

  task automatic test_back_to_back();
    int bc, dc; bit gd, ab; logic [7:0] got;
    for (int i = 0; i < 8; i++) ramWrite(8'h30 + 8'(i), 8'h00);
    issue(MODE_FILL, 8'h00, 8'h30, 9'd5, 8'h3C, 999);
    fork
      waitDone(30, bc, dc, gd, ab);
      begin
        tick();
        start = 1'b1; mode = MODE_COPY; src_addr = 8'h00; dst_addr = 8'h31; len = 9'd2;
        tick();
        start = 1'b0;
      end
    join
    checkCount++;
    if (!gd || ab || bc != 5 || dc != 5)
      $display("[TB] FAIL busy_start got done=%b aborted=%b busy=%0d doneAt=%0d expected 1 0 5 5", gd, ab, bc, dc);
    else passCount++;
    issue(MODE_FILL, 8'h00, 8'h36, 9'd1, 8'h3D, 999);
    tick();
    start = 1'b1; mode = MODE_FILL; dst_addr = 8'h37; len = 9'd3; fill_data = 8'hFF;
    @(negedge clk);
    checkCount++;
    if (done !== 1'b1) $display("[TB] FAIL fin_done got done=%b expected 1", done);
    else passCount++;
    tick();
    start = 1'b0;
    @(negedge clk);
    checkCount++;
    if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL fin_start got busy=%b done=%b expected 0 0", busy, done);
    else passCount++;
    tick();
    for (int i = 0; i < 8; i++) begin
      ramRead(8'h30 + 8'(i), got);
      checkCount++;
      if (got !== shadow[8'h30 + 8'(i)])
        $display("[TB] FAIL b2b_mem[%02h] got=%02h expected=%02h", 8'h30 + 8'(i), got, shadow[8'h30 + 8'(i)]);
      else passCount++;
    end
  endtask

  task automatic test_len_clamp();
    int bc, dc; bit gd, ab; logic [7:0] got; logic [7:0] addrs [3];
    addrs = '{8'h00, 8'h7F, 8'hFF};
    issue(MODE_FILL, 8'h00, 8'h00, 9'h1FF, 8'h96, 999);
    waitDone(300, bc, dc, gd, ab);
    checkCount++;
    if (!gd || bc != 256 || dc != 256 || expQ.size() != 0)
      $display("[TB] FAIL len_clamp got done=%b busy=%0d doneAt=%0d outstanding=%0d expected 1 256 256 0",
               gd, bc, dc, expQ.size());
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      ramRead(addrs[i], got);
      checkCount++;
      if (got !== shadow[addrs[i]]) $display("[TB] FAIL clamp_mem[%02h] got=%02h expected=%02h", addrs[i], got, shadow[addrs[i]]);
      else passCount++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_overlap();
    test_wrap_and_zero();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_len_clamp();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
